// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned DEF_XLEN    = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Queue entry layout at the default datapath width.
    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [INSTR_W-1:0]  instr;
        logic                fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: decode handshake, execute redirect and instruction-memory write port.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
);

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_fault;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               imem_we;
    logic [XLEN-1:0]    imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;

    // Fetch-unit side.
    modport master (
        output out_valid, out_pc, out_instr, out_fault,
        input  out_ready, redirect_valid, redirect_pc,
        input  imem_we, imem_waddr, imem_wdata
    );

    // Decode / execute / loader side.
    modport slave (
        input  out_valid, out_pc, out_instr, out_fault,
        output out_ready, redirect_valid, redirect_pc,
        output imem_we, imem_waddr, imem_wdata
    );

endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO with flush; a full queue may push in the cycle it pops.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  entry_t        wdata_i,
    output entry_t        head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    entry_t        slot_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Flush wins over any same-cycle push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PW'(1);
            if (pop_i)  head_d = head_q + PW'(1);
            if (push_i && !pop_i)      count_d = count_q + CW'(1);
            else if (!push_i && pop_i) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) slot_q[tail_q] <= wdata_i;
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? slot_q[head_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Sequential-PC instruction fetch with byte-addressed imem and a prefetch queue.
// Define FETCH_PERF_EN to add saturating fetched/stall/flush counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     IMEM_BYTES = 4096,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
)(
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [15:0] perf_flush
`endif
);

    localparam int unsigned AW = $clog2(IMEM_BYTES);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               fault;
    } entry_t;

    logic [XLEN-1:0]    fpc_q, fpc_d;
    logic [7:0]         imem_q [IMEM_BYTES];
    logic [INSTR_W-1:0] rdata_c;
    logic               rfault_c;
    logic [XLEN-1:0]    baddr_c;
    logic [XLEN-1:0]    wbase_c;
    logic               wen_c;
    logic               pop_c, push_c, redirect_c;
    logic               q_valid;
    logic [CW-1:0]      q_count;
    entry_t             q_head, q_wdata;

    // Fetch word at fpc; any out-of-range byte turns the whole word into a faulting NOP.
    always_comb begin
        rdata_c  = '0;
        rfault_c = 1'b0;
        baddr_c  = '0;
        for (int k = 0; k < int'(INSTR_BYTES); k++) begin
            baddr_c = fpc_q + XLEN'(k);
            if (baddr_c >= XLEN'(IMEM_BYTES)) rfault_c = 1'b1;
            else rdata_c[8*k +: 8] = imem_q[baddr_c[AW-1:0]];
        end
        if (rfault_c) rdata_c = NOP_INSTR;
    end

    assign redirect_c = bus.redirect_valid;
    assign pop_c      = q_valid & bus.out_ready;
    assign push_c     = (q_count < CW'(DEPTH)) | pop_c;
    assign q_wdata    = '{pc: fpc_q, instr: rdata_c, fault: rfault_c};

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c & ~redirect_c),
        .pop_i   (pop_c & ~redirect_c),
        .flush_i (redirect_c),
        .wdata_i (q_wdata),
        .head_o  (q_head),
        .valid_o (q_valid),
        .count_o (q_count)
    );

    always_comb begin
        fpc_d = fpc_q;
        if (redirect_c)  fpc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
        else if (push_c) fpc_d = fpc_q + XLEN'(INSTR_BYTES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fpc_q <= RESET_PC;
        else     fpc_q <= fpc_d;
    end

    // Memory is not reset; the same-edge fetch above sees the pre-write bytes.
    assign wbase_c = {bus.imem_waddr[XLEN-1:2], 2'b00};
    assign wen_c   = bus.imem_we & (wbase_c < XLEN'(IMEM_BYTES));

    always_ff @(posedge clk) begin
        if (wen_c) begin
            for (int k = 0; k < int'(INSTR_BYTES); k++) begin
                imem_q[wbase_c[AW-1:0] + AW'(k)] <= bus.imem_wdata[8*k +: 8];
            end
        end
    end

    assign bus.out_valid = q_valid;
    assign bus.out_pc    = q_head.pc;
    assign bus.out_instr = q_head.instr;
    assign bus.out_fault = q_head.fault;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, stall_q;
    logic [15:0] flush_q;

    // Saturating event counters; a pop discarded by a redirect is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            if (pop_c && !redirect_c && !(&fetched_q)) fetched_q <= fetched_q + 32'd1;
            if (q_valid && !bus.out_ready && !(&stall_q)) stall_q <= stall_q + 32'd1;
            if (redirect_c && !(&flush_q)) flush_q <= flush_q + 16'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
    assign perf_flush   = flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (optionally with FETCH_PERF_EN).
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fetch_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
    logic [15:0] perf_flush;
`endif

    fetch_unit #(
        .XLEN       (32),
        .IMEM_BYTES (4096),
        .DEPTH      (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = addr;
        bus.imem_wdata = data;
        step();
        bus.imem_we    = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                               input logic fault);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(1'b1));
        check({tag, ".pc"},    64'(bus.out_pc),    64'(pc));
        check({tag, ".instr"}, 64'(bus.out_instr), 64'(instr));
        check({tag, ".fault"}, 64'(bus.out_fault), 64'(fault));
    endtask

    task automatic expect_empty(input string tag);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(1'b0));
        check({tag, ".pc"},    64'(bus.out_pc),    64'(0));
        check({tag, ".instr"}, 64'(bus.out_instr), 64'(0));
        check({tag, ".fault"}, 64'(bus.out_fault), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_we        = 1'b0;
        bus.imem_waddr     = '0;
        bus.imem_wdata     = '0;

        // Program image loaded while reset holds the fetch side idle.
        load(32'h0, 32'h1111_1111);
        load(32'h4, 32'h2222_2222);
        load(32'h8, 32'h3333_3333);
        load(32'hC, 32'h4444_4444);
        for (int a = 16; a < 48; a += 4) load(32'(a), 32'hA000_0000 | 32'(a));
        load(32'h100, 32'hB000_0100);
        load(32'h104, 32'hB000_0104);
        load(32'h200, 32'hB000_0200);
        load(32'hFFC, 32'hCAFE_F00D);

        expect_empty("reset");
`ifdef FETCH_PERF_EN
        check("reset.perf_fetched", 64'(perf_fetched), 64'(0));
        check("reset.perf_stall",   64'(perf_stall),   64'(0));
        check("reset.perf_flush",   64'(perf_flush),   64'(0));
`endif

        // Streaming from RESET_PC with decode always ready.
        bus.out_ready = 1'b1;
        rst = 1'b0;
        check("pre_edge.valid", 64'(bus.out_valid), 64'(1'b0));
        step();
        expect_head("s0", 32'h0, 32'h1111_1111, 1'b0);
        step();
        expect_head("s1", 32'h4, 32'h2222_2222, 1'b0);
        step();
        expect_head("s2", 32'h8, 32'h3333_3333, 1'b0);
        step();
        expect_head("s3", 32'hC, 32'h4444_4444, 1'b0);

        // Stall: head holds, queue fills, nothing is lost or duplicated on release.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        expect_head("stall", 32'hC, 32'h4444_4444, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_head("release", 32'h10 + 32'(4*i), 32'hA000_0010 + 32'(4*i), 1'b0);
        end

        // Redirect to an unaligned target while the queue is full.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        step();
        bus.redirect_valid = 1'b0;
        expect_empty("redir1_gap");
        step();
        expect_head("redir1_t0", 32'h100, 32'hB000_0100, 1'b0);
        step();
        expect_head("redir1_t1", 32'h104, 32'hB000_0104, 1'b0);

        // Run off the end of instruction memory.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFC;
        step();
        bus.redirect_valid = 1'b0;
        expect_empty("redir2_gap");
        step();
        expect_head("edge_last", 32'hFFC, 32'hCAFE_F00D, 1'b0);
        step();
        expect_head("edge_oob0", 32'h1000, 32'h0000_0013, 1'b1);
        step();
        expect_head("edge_oob1", 32'h1004, 32'h0000_0013, 1'b1);

        // Write to the word being fetched: the fetch sees the old data.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_we        = 1'b1;
        bus.imem_waddr     = 32'h202;
        bus.imem_wdata     = 32'hDEAD_BEEF;
        step();
        bus.imem_we        = 1'b0;
        expect_head("rbw_old", 32'h200, 32'hB000_0200, 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        step();
        expect_head("rbw_new", 32'h200, 32'hDEAD_BEEF, 1'b0);

        // Out-of-range write must not alias onto word 0.
        load(32'h1000, 32'h5555_5555);

`ifdef FETCH_PERF_EN
        check("perf.flush", 64'(perf_flush), 64'(4));
        check("perf.stall", 64'(perf_stall), 64'(14));
`endif

        // Asynchronous reset mid-stream.
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        expect_empty("midrst");
`ifdef FETCH_PERF_EN
        check("midrst.perf_fetched", 64'(perf_fetched), 64'(0));
        check("midrst.perf_stall",   64'(perf_stall),   64'(0));
        check("midrst.perf_flush",   64'(perf_flush),   64'(0));
`endif
        step();
        rst = 1'b0;
        step();
        expect_head("restart0", 32'h0, 32'h1111_1111, 1'b0);
        step();
        expect_head("restart1", 32'h4, 32'h2222_2222, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
